// File: rtl/key_press_if.sv
// rtl/key_press_if.sv - debounced key inputs and classified press outputs
interface key_press_if;
  logic button_level;
  logic button_negedge;
  logic button_posedge;
  logic short_press;
  logic long_press;
  logic repeat_press;
  logic busy;

  modport master (
    output button_level, button_negedge, button_posedge,
    input  short_press, long_press, repeat_press, busy
  );

  modport slave (
    input  button_level, button_negedge, button_posedge,
    output short_press, long_press, repeat_press, busy
  );
endinterface

// File: rtl/key_press_classifier.sv
// rtl/key_press_classifier.sv - classifies a debounced key into short, long and auto-repeat presses
module key_press_classifier #(
  parameter int LONG_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000,
  parameter int REPEAT_EN     = 1
) (
  input logic        clk,
  input logic        rst,
  key_press_if.slave kp
);
  localparam int MAX_CYCLES = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES) + 1;
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PRESSED, HELD} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          short_nxt, long_nxt, rep_nxt;
  logic          short_q, long_q, rep_q, busy_q;
  logic          press, release_ev;

  // A press and a release in the same cycle cancel each other out.
  assign press      = kp.button_negedge & ~kp.button_posedge;
  assign release_ev = kp.button_posedge & ~kp.button_negedge;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    short_nxt = 1'b0;
    long_nxt  = 1'b0;
    rep_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (press) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
        end
      end
      PRESSED: begin
        // Release beats the long threshold when both land on the same edge.
        if (release_ev) begin
          short_nxt = 1'b1;
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (kp.button_level) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == LONG_LAST) begin
          long_nxt  = 1'b1;
          state_nxt = HELD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      HELD: begin
        if (release_ev || kp.button_level) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (REPEAT_EN != 0) begin
          if (cnt == REP_LAST) begin
            rep_nxt = 1'b1;
            cnt_nxt = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      rep_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      short_q <= short_nxt;
      long_q  <= long_nxt;
      rep_q   <= rep_nxt;
      busy_q  <= (state_nxt != IDLE);
    end
  end

  assign kp.short_press  = short_q;
  assign kp.long_press   = long_q;
  assign kp.repeat_press = rep_q;
  assign kp.busy         = busy_q;
endmodule

// File: tb/tb_key_press_classifier.sv
// tb/tb_key_press_classifier.sv - directed vector bench for key_press_classifier
module tb_key_press_classifier;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  key_press_if ka ();
  key_press_if kb ();

  key_press_classifier #(.LONG_CYCLES(100), .REPEAT_CYCLES(20), .REPEAT_EN(1)) dut_a (
    .clk(clk), .rst(rst), .kp(ka.slave)
  );
  key_press_classifier #(.LONG_CYCLES(100), .REPEAT_CYCLES(20), .REPEAT_EN(0)) dut_b (
    .clk(clk), .rst(rst), .kp(kb.slave)
  );

  typedef struct {
    string name;
    int pos_k;      // release edge offset, 0 = none
    int guard_k;    // level goes high without posedge, 0 = none
    int neg2_k;     // spurious second negedge, 0 = none
    int rst_k;      // single reset edge, 0 = none
    int len;
    int exp_short;  // offset of short_press edge, -1 = none
    int exp_long;
    int exp_rep;
    int rep_first;
    int rep_last;
    int busy_end;
  } vec_t;

  vec_t vecs[9];
  int passed = 0;
  int total  = 0;
  int s_cnt[2], s_off[2], l_cnt[2], l_off[2], r_cnt[2], r_first[2], r_last[2];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic drive(input logic r, input logic lvl, input logic n, input logic p);
    rst = r;
    ka.button_level = lvl; ka.button_negedge = n; ka.button_posedge = p;
    kb.button_level = lvl; kb.button_negedge = n; kb.button_posedge = p;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v);
    logic [3:0] o [2];
    logic lvl;
    for (int d = 0; d < 2; d++) begin
      s_cnt[d] = 0; s_off[d] = -1; l_cnt[d] = 0; l_off[d] = -1;
      r_cnt[d] = 0; r_first[d] = -1; r_last[d] = -1;
    end
    for (int i = 0; i <= v.len; i++) begin
      lvl = (i != 0) && ((v.pos_k > 0 && i >= v.pos_k) || (v.guard_k > 0 && i >= v.guard_k));
      drive(!(v.rst_k > 0 && i == v.rst_k), lvl,
            (i == 0) || (v.neg2_k > 0 && i == v.neg2_k), (v.pos_k > 0 && i == v.pos_k));
      step();
      o[0] = {ka.short_press, ka.long_press, ka.repeat_press, ka.busy};
      o[1] = {kb.short_press, kb.long_press, kb.repeat_press, kb.busy};
      if (i == 0) check({v.name, " busy_after_press"}, int'(o[0][0]), 1);
      for (int d = 0; d < 2; d++) begin
        if (o[d][3]) begin s_cnt[d]++; if (s_off[d] < 0) s_off[d] = i; end
        if (o[d][2]) begin l_cnt[d]++; if (l_off[d] < 0) l_off[d] = i; end
        if (o[d][1]) begin r_cnt[d]++; if (r_first[d] < 0) r_first[d] = i; r_last[d] = i; end
      end
    end
    check({v.name, " short_cnt"}, s_cnt[0], (v.exp_short >= 0) ? 1 : 0);
    check({v.name, " short_off"}, s_off[0], v.exp_short);
    check({v.name, " long_cnt"},  l_cnt[0], (v.exp_long >= 0) ? 1 : 0);
    check({v.name, " long_off"},  l_off[0], v.exp_long);
    check({v.name, " rep_cnt"},   r_cnt[0], v.exp_rep);
    check({v.name, " rep_first"}, r_first[0], v.rep_first);
    check({v.name, " rep_last"},  r_last[0], v.rep_last);
    check({v.name, " busy_end"},  int'(ka.busy), v.busy_end);
    check({v.name, " noreb_short_off"}, s_off[1], v.exp_short);
    check({v.name, " noreb_long_cnt"},  l_cnt[1], (v.exp_long >= 0) ? 1 : 0);
    check({v.name, " noreb_long_off"},  l_off[1], v.exp_long);
    check({v.name, " noreb_rep_cnt"},   r_cnt[1], 0);
    check({v.name, " noreb_busy_end"},  int'(kb.busy), v.busy_end);
    // Let the level guard return both blocks to IDLE before the next vector.
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step();
  endtask

  initial begin
    //            name         pos  grd neg2 rst len  short long rep first last busy
    vecs[0] = '{"short50",     50,  0,  0,   0,  60,  50,  -1,  0, -1,  -1,  0};
    vecs[1] = '{"edge100",     100, 0,  0,   0,  110, 100, -1,  0, -1,  -1,  0};
    vecs[2] = '{"edge101",     101, 0,  0,   0,  110, -1,  100, 0, -1,  -1,  0};
    vecs[3] = '{"hold165",     165, 0,  0,   0,  180, -1,  100, 3, 120, 160, 0};
    vecs[4] = '{"rst_hold",    130, 0,  0,   110,140, -1,  100, 0, -1,  -1,  0};
    vecs[5] = '{"short1",      1,   0,  0,   0,  10,  1,   -1,  0, -1,  -1,  0};
    vecs[6] = '{"guard",       0,   30, 0,   0,  60,  -1,  -1,  0, -1,  -1,  0};
    vecs[7] = '{"renegedge",   150, 0,  40,  0,  160, -1,  100, 2, 120, 140, 0};
    vecs[8] = '{"hold200",     0,   0,  0,   0,  200, -1,  100, 5, 120, 200, 1};

    drive(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, i[0], ~i[0], i[1]);
      step();
      check($sformatf("reset_outs_a%0d", i),
            int'({ka.short_press, ka.long_press, ka.repeat_press, ka.busy}), 0);
      check($sformatf("reset_outs_b%0d", i),
            int'({kb.short_press, kb.long_press, kb.repeat_press, kb.busy}), 0);
    end

    for (int k = 0; k < 9; k++) run_vec(vecs[k]);

    drive(1'b1, 1'b1, 1'b1, 1'b1);
    step();
    check("both_edges_busy", int'(ka.busy), 0);
    check("both_edges_outs", int'({ka.short_press, ka.long_press, ka.repeat_press}), 0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    step();
    check("both_edges_idle", int'({ka.short_press, ka.long_press, ka.repeat_press, ka.busy}), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/key_press_classifier.md
KEY_PRESS_CLASSIFIER -- requirements
Module: key_press_classifier

Interface
REQ-001 The block SHALL have parameter LONG_CYCLES, default 50_000_000, meaning clock cycles held before a long press (1 s at 50 MHz); legal minimum 2.
REQ-002 The block SHALL have parameter REPEAT_CYCLES, default 10_000_000, meaning clock cycles between auto-repeat pulses while held (200 ms); legal minimum 2.
REQ-003 The block SHALL have parameter REPEAT_EN, default 1, meaning 1 enables auto-repeat and 0 disables it.
REQ-004 clk  input  1  system clock; all logic on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-low; low at a rising clk edge resets the block.
REQ-006 button_level  input  1  debounced key level from the upstream debouncer; 0 = pressed, 1 = released.
REQ-007 button_negedge  input  1  one-cycle pulse marking the press (1->0) of button_level.
REQ-008 button_posedge  input  1  one-cycle pulse marking the release (0->1) of button_level.
REQ-009 short_press  output  1  one-cycle pulse; key released before LONG_CYCLES.
REQ-010 long_press  output  1  one-cycle pulse; key held for LONG_CYCLES.
REQ-011 repeat_press  output  1  one-cycle pulse every REPEAT_CYCLES while held after long_press.
REQ-012 busy  output  1  high while state is not IDLE.

Function
REQ-013 The FSM SHALL have three states: IDLE, PRESSED, HELD; one cycle counter, width clog2(max(LONG_CYCLES,REPEAT_CYCLES))+1, unsigned.
REQ-014 All outputs SHALL be registered; every pulse output SHALL be high for exactly one cycle.
REQ-015 IDLE: button_negedge sampled at edge T0 -> PRESSED, counter cleared to 0; button_posedge in IDLE ignored.
REQ-016 PRESSED: counter increments each edge; button_posedge sampled at edge T0+k with 1 <= k <= LONG_CYCLES -> short_press high in the cycle after that edge, next state IDLE.
REQ-017 PRESSED: no posedge at edges T0+1..T0+LONG_CYCLES -> long_press high in the cycle after edge T0+LONG_CYCLES, next state HELD, counter cleared.
REQ-018 Simultaneous release and long threshold at the same edge: release wins; short_press only, no long_press.
REQ-019 HELD with REPEAT_EN=1: repeat_press high in the cycle after every REPEAT_CYCLES-th edge counted from the long_press edge; counter wraps to 0 at each pulse.
REQ-020 HELD with REPEAT_EN=0: counter frozen, repeat_press never asserted.
REQ-021 HELD: button_posedge -> IDLE with no pulse; release coinciding with a repeat threshold suppresses that repeat_press.
REQ-022 button_negedge while in PRESSED or HELD SHALL be ignored (no restart).
REQ-023 Guard: in PRESSED or HELD, button_level sampled 1 without button_posedge -> IDLE silently, no pulse.
REQ-024 button_negedge and button_posedge asserted in the same cycle SHALL both be ignored.
REQ-025 Counter SHALL never wrap past its threshold; no pulse SHALL be produced from counter overflow.

Reset
REQ-026 rst low at a clock edge SHALL force state IDLE, counter 0, short_press=0, long_press=0, repeat_press=0, busy=0 in the following cycle, overriding all inputs.
REQ-027 Reset mid-PRESSED or mid-HELD SHALL discard the press; a later button_posedge SHALL produce no pulse.
REQ-028 After rst returns high, the block SHALL accept a button_negedge at the very next edge.

Verification (LONG_CYCLES=100, REPEAT_CYCLES=20, REPEAT_EN=1 unless stated)
REQ-029 Reset: rst=0 for 5 cycles while toggling button inputs -> all outputs 0 throughout, busy=0.
REQ-030 Short press: negedge at T0, posedge at T0+50 -> short_press high one cycle after T0+50; long_press, repeat_press never high.
REQ-031 Boundary: negedge at T0, posedge at T0+100 -> short_press only; posedge at T0+101 -> long_press after T0+100, no short_press.
REQ-032 Hold and repeat: negedge at T0, posedge at T0+165 -> long_press after T0+100, repeat_press after T0+120, T0+140, T0+160; no further pulses; busy falls after T0+165.
REQ-033 Reset mid-hold: negedge at T0, rst=0 at T0+110, posedge at T0+130 -> no pulses after reset edge; busy=0.
REQ-034 REPEAT_EN=0: negedge at T0, hold 200 cycles -> single long_press after T0+100, zero repeat_press.
